l2_msg_sched: RTL and testbench
===============================

Name: l2_msg_sched

Overview:
- Single-entry message scheduler in front of the PMESH L2 line-processing datapath.
- Arbitrates the request channel (msg1) and the ack/response channel (msg3) into one issue port, and parks a request that must wait for invalidation acks.
- Replays the parked request once the datapath signals completion; publishes cur_msg_state (0 fresh, 1 parked, 2 replay) and the parked message fields.
- Gates every issue on msg2 output availability.

Parameters:
TYPE_W, 8, message type width
SRC_W, 6, source/owner id width
TAG_W, 26, line tag width
DATA_W, 64, data width
PARK_TIMEOUT, 200, parked cycles before park_timeout asserts (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
msg1_valid/msg1_ready  in/out  1/1  request handshake
msg1_type/msg1_source/msg1_tag/msg1_data  in  TYPE_W/SRC_W/TAG_W/DATA_W  request payload
msg3_valid/msg3_ready  in/out  1/1  ack handshake
msg3_type/msg3_source/msg3_tag/msg3_data  in  TYPE_W/SRC_W/TAG_W/DATA_W  ack payload
msg2_ready  in  1  response channel can take one message
pipe_valid  out  1  issue to datapath
pipe_ready  in  1  datapath consumes issue this cycle
pipe_type/pipe_source/pipe_tag/pipe_data  out  widths as above  issued payload
pipe_from_msg3  out  1  issued message came from msg3
pipe_park  in  1  with pipe_ready: request must wait for acks
pipe_wake  in  1  with pipe_ready: final ack consumed, replay parked request
cur_msg_state  out  2  0 none/fresh, 1 parked, 2 replay
cur_msg_type/cur_msg_source/cur_msg_tag  out  TYPE_W/SRC_W/TAG_W  parked request
park_timeout  out  1  parked too long (level)
proto_err  out  1  sticky protocol violation

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM=IDLE.
  - pipe_valid=0, msg1_ready=0, msg3_ready=0.
  - cur_msg_* =0, cur_msg_state=0.
  - Capture register =0, park counter =0, park_timeout=0, proto_err=0.
  - Reset mid-operation discards captured and parked messages.
- FSM states: IDLE, ISSUE, PARKED, ACK_ISSUE, REPLAY.
- Readies are combinational from state and are 0 while rst_n=0:
  - msg3_ready=1 in IDLE and PARKED.
  - msg1_ready=1 only in IDLE with msg3_valid=0, so msg3 wins simultaneous arrivals.
  - Both readies are 0 in ISSUE, ACK_ISSUE and REPLAY.
- Accept = valid & ready. The payload is latched into the capture register with the source flag, and the next state is ISSUE (from IDLE) or ACK_ISSUE (from PARKED).
- Issue gating: pipe_valid=1 in ISSUE, ACK_ISSUE or REPLAY only when msg2_ready=1. Payload is stable while pipe_valid=1 and pipe_ready=0. Minimum accept-to-issue latency is 1 cycle.
- ISSUE completes on pipe_valid & pipe_ready:
  - pipe_park=1 on a msg1 issue: copy type/source/tag to cur_msg_*, set cur_msg_state=1, go to PARKED.
  - pipe_park=1 on a msg3 issue: set proto_err, go to IDLE.
  - Otherwise go to IDLE.
  - pipe_wake in ISSUE is ignored.
- ACK_ISSUE (pipe_from_msg3=1) completes on pipe_valid & pipe_ready:
  - pipe_wake=1: set cur_msg_state=2, go to REPLAY.
  - Otherwise return to PARKED.
  - pipe_park=1 here sets proto_err.
- REPLAY drives the cur_msg_* fields with pipe_data=0 and pipe_from_msg3=0. It completes on pipe_valid & pipe_ready:
  - pipe_park=1: cur_msg_state=1, go to PARKED, park counter cleared.
  - Otherwise cur_msg_state=0, go to IDLE.
- Park counter (8 bit):
  - Cleared on entry to PARKED.
  - Increments each cycle in PARKED or ACK_ISSUE and saturates at 255.
  - park_timeout = (counter >= PARK_TIMEOUT) while parked. It clears on entering REPLAY, and that clear is not sticky.
- proto_err stays set until reset.
- pipe_park and pipe_wake both set with pipe_ready: pipe_park takes priority and proto_err is set.

Test Plan:
- Plain msg1 accept:
  - Stimulus: IDLE, msg1_valid=1, type=0x1f, source=5, tag=0x123, msg2_ready=1, pipe_ready=1, no park.
  - Response: accepted cycle 0; pipe_valid=1 with identical payload cycle 1; IDLE cycle 2; cur_msg_state stays 0.
- Simultaneous arrival:
  - Stimulus: msg1_valid=1 and msg3_valid=1 in IDLE.
  - Response: msg3_ready=1, msg1_ready=0; msg3 issued first with pipe_from_msg3=1; msg1 accepted on the next IDLE cycle.
- Backpressure:
  - Stimulus: msg2_ready=0 for 3 cycles after accept.
  - Response: pipe_valid=0 for those 3 cycles; pipe_valid=1 the cycle msg2_ready rises; payload unchanged.
- Park, acks, replay:
  - Stimulus: msg1 with source=9, tag=0xABC issued with pipe_park=1; two msg3 acks, the second with pipe_wake=1.
  - Response: cur_msg_state goes 1, then 2, then 0; msg1_ready=0 throughout; the replay shows pipe_source=9, pipe_tag=0xABC.
- Timeout:
  - Stimulus: PARK_TIMEOUT=4, request parked, no acks.
  - Response: park_timeout=1 from the 4th parked cycle; cleared on entering REPLAY.
- Reset and protocol error:
  - Stimulus: pipe_park=1 on a msg3 issue from IDLE, then rst_n=0 for one edge while parked.
  - Response: proto_err=1 until reset; after reset all outputs are at reset values and the FSM is IDLE.

Source files
------------

// File: rtl/l2_msg_sched.sv
`timescale 1ns/1ps
// l2_msg_sched: single-entry scheduler in front of the L2 line datapath.
// Arbitrates request (msg1) and ack (msg3) traffic into one issue port. A
// request that must wait for invalidation acks is parked and then replayed
// once the datapath reports that the final ack has been consumed.
module l2_msg_sched #(
  parameter int TYPE_W       = 8,
  parameter int SRC_W        = 6,
  parameter int TAG_W        = 26,
  parameter int DATA_W       = 64,
  parameter int PARK_TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg1_valid,
  output logic              msg1_ready,
  input  logic [TYPE_W-1:0] msg1_type,
  input  logic [SRC_W-1:0]  msg1_source,
  input  logic [TAG_W-1:0]  msg1_tag,
  input  logic [DATA_W-1:0] msg1_data,
  input  logic              msg3_valid,
  output logic              msg3_ready,
  input  logic [TYPE_W-1:0] msg3_type,
  input  logic [SRC_W-1:0]  msg3_source,
  input  logic [TAG_W-1:0]  msg3_tag,
  input  logic [DATA_W-1:0] msg3_data,
  input  logic              msg2_ready,
  output logic              pipe_valid,
  input  logic              pipe_ready,
  output logic [TYPE_W-1:0] pipe_type,
  output logic [SRC_W-1:0]  pipe_source,
  output logic [TAG_W-1:0]  pipe_tag,
  output logic [DATA_W-1:0] pipe_data,
  output logic              pipe_from_msg3,
  input  logic              pipe_park,
  input  logic              pipe_wake,
  output logic [1:0]        cur_msg_state,
  output logic [TYPE_W-1:0] cur_msg_type,
  output logic [SRC_W-1:0]  cur_msg_source,
  output logic [TAG_W-1:0]  cur_msg_tag,
  output logic              park_timeout,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_PARKED    = 3'd2,
    ST_ACK_ISSUE = 3'd3,
    ST_REPLAY    = 3'd4
  } state_t;

  localparam logic [1:0] CUR_NONE   = 2'd0;
  localparam logic [1:0] CUR_PARKED = 2'd1;
  localparam logic [1:0] CUR_REPLAY = 2'd2;
  localparam logic [8:0] PT9        = 9'(PARK_TIMEOUT);

  state_t              state;
  logic [TYPE_W-1:0]   cap_type;
  logic [SRC_W-1:0]    cap_source;
  logic [TAG_W-1:0]    cap_tag;
  logic [DATA_W-1:0]   cap_data;
  logic                cap_from3;
  logic [7:0]          park_cnt;
  logic [7:0]          park_cnt_inc;
  logic                hit_entry;
  logic                hit_inc;
  logic                msg1_acc;
  logic                msg3_acc;
  logic                fire;

  // Channel readies: msg3 wins a tie in IDLE; nothing is accepted while an issue is pending.
  always_comb begin
    msg1_ready = 1'b0;
    msg3_ready = 1'b0;
    if (!rst_n) begin
      msg1_ready = 1'b0;
      msg3_ready = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          msg3_ready = 1'b1;
          msg1_ready = ~msg3_valid;
        end
        ST_PARKED: begin
          msg3_ready = 1'b1;
        end
        default: begin
          msg1_ready = 1'b0;
          msg3_ready = 1'b0;
        end
      endcase
    end
  end

  // Issue gating on msg2 space, handshake decode and park-timer lookahead.
  always_comb begin
    pipe_valid = 1'b0;
    if (rst_n && (state == ST_ISSUE || state == ST_ACK_ISSUE || state == ST_REPLAY)) begin
      pipe_valid = msg2_ready;
    end else begin
      pipe_valid = 1'b0;
    end
    fire     = pipe_valid & pipe_ready;
    msg1_acc = msg1_valid & msg1_ready;
    msg3_acc = msg3_valid & msg3_ready;
    // park_cnt holds the number of completed parked cycles, so the cycle
    // being entered is number park_cnt_next + 1.
    if (park_cnt == 8'hff) begin
      park_cnt_inc = 8'hff;
    end else begin
      park_cnt_inc = park_cnt + 8'd1;
    end
    hit_inc   = ({1'b0, park_cnt_inc} + 9'd1) >= PT9;
    hit_entry = 9'd1 >= PT9;
  end

  assign pipe_type      = cap_type;
  assign pipe_source    = cap_source;
  assign pipe_tag       = cap_tag;
  assign pipe_data      = cap_data;
  assign pipe_from_msg3 = cap_from3;

  // Scheduler FSM with capture register, parked-message record, park timer and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cap_type       <= '0;
      cap_source     <= '0;
      cap_tag        <= '0;
      cap_data       <= '0;
      cap_from3      <= 1'b0;
      cur_msg_state  <= CUR_NONE;
      cur_msg_type   <= '0;
      cur_msg_source <= '0;
      cur_msg_tag    <= '0;
      park_cnt       <= 8'd0;
      park_timeout   <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          park_cnt     <= 8'd0;
          park_timeout <= 1'b0;
          if (msg3_acc) begin
            cap_type   <= msg3_type;
            cap_source <= msg3_source;
            cap_tag    <= msg3_tag;
            cap_data   <= msg3_data;
            cap_from3  <= 1'b1;
            state      <= ST_ISSUE;
          end else if (msg1_acc) begin
            cap_type   <= msg1_type;
            cap_source <= msg1_source;
            cap_tag    <= msg1_tag;
            cap_data   <= msg1_data;
            cap_from3  <= 1'b0;
            state      <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (fire && pipe_park && cap_from3) begin
            // An ack can never be parked.
            proto_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (fire && pipe_park) begin
            cur_msg_type   <= cap_type;
            cur_msg_source <= cap_source;
            cur_msg_tag    <= cap_tag;
            cur_msg_state  <= CUR_PARKED;
            park_cnt       <= 8'd0;
            park_timeout   <= hit_entry;
            if (pipe_wake) begin
              proto_err <= 1'b1;
            end else begin
              proto_err <= proto_err;
            end
            state <= ST_PARKED;
          end else if (fire) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_PARKED: begin
          park_cnt     <= park_cnt_inc;
          park_timeout <= hit_inc;
          if (msg3_acc) begin
            cap_type   <= msg3_type;
            cap_source <= msg3_source;
            cap_tag    <= msg3_tag;
            cap_data   <= msg3_data;
            cap_from3  <= 1'b1;
            state      <= ST_ACK_ISSUE;
          end else begin
            state <= ST_PARKED;
          end
        end
        ST_ACK_ISSUE: begin
          park_cnt     <= park_cnt_inc;
          park_timeout <= hit_inc;
          if (fire && pipe_park) begin
            proto_err <= 1'b1;
            state     <= ST_PARKED;
          end else if (fire && pipe_wake) begin
            // Load the parked request into the issue register for replay.
            cap_type      <= cur_msg_type;
            cap_source    <= cur_msg_source;
            cap_tag       <= cur_msg_tag;
            cap_data      <= '0;
            cap_from3     <= 1'b0;
            cur_msg_state <= CUR_REPLAY;
            park_cnt      <= 8'd0;
            park_timeout  <= 1'b0;
            state         <= ST_REPLAY;
          end else if (fire) begin
            state <= ST_PARKED;
          end else begin
            state <= ST_ACK_ISSUE;
          end
        end
        ST_REPLAY: begin
          park_cnt     <= 8'd0;
          park_timeout <= 1'b0;
          if (fire && pipe_park) begin
            cur_msg_state <= CUR_PARKED;
            park_timeout  <= hit_entry;
            if (pipe_wake) begin
              proto_err <= 1'b1;
            end else begin
              proto_err <= proto_err;
            end
            state <= ST_PARKED;
          end else if (fire) begin
            cur_msg_state <= CUR_NONE;
            state         <= ST_IDLE;
          end else begin
            state <= ST_REPLAY;
          end
        end
        default: begin
          state         <= ST_IDLE;
          cur_msg_state <= CUR_NONE;
          park_cnt      <= 8'd0;
          park_timeout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_msg_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for l2_msg_sched: every accepted message pushes its
// expected issue payload; the issue monitor pops and compares on each
// datapath handshake. State outputs are checked cycle by cycle.
module tb_l2_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msg1_valid, msg1_ready;
  logic [7:0]  msg1_type;
  logic [5:0]  msg1_source;
  logic [25:0] msg1_tag;
  logic [63:0] msg1_data;
  logic        msg3_valid, msg3_ready;
  logic [7:0]  msg3_type;
  logic [5:0]  msg3_source;
  logic [25:0] msg3_tag;
  logic [63:0] msg3_data;
  logic        msg2_ready;
  logic        pipe_valid, pipe_ready;
  logic [7:0]  pipe_type;
  logic [5:0]  pipe_source;
  logic [25:0] pipe_tag;
  logic [63:0] pipe_data;
  logic        pipe_from_msg3, pipe_park, pipe_wake;
  logic [1:0]  cur_msg_state;
  logic [7:0]  cur_msg_type;
  logic [5:0]  cur_msg_source;
  logic [25:0] cur_msg_tag;
  logic        park_timeout, proto_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] sb[$];

  l2_msg_sched #(.PARK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg1_valid(msg1_valid), .msg1_ready(msg1_ready), .msg1_type(msg1_type),
    .msg1_source(msg1_source), .msg1_tag(msg1_tag), .msg1_data(msg1_data),
    .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
    .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
    .msg2_ready(msg2_ready), .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
    .pipe_type(pipe_type), .pipe_source(pipe_source), .pipe_tag(pipe_tag),
    .pipe_data(pipe_data), .pipe_from_msg3(pipe_from_msg3), .pipe_park(pipe_park),
    .pipe_wake(pipe_wake), .cur_msg_state(cur_msg_state), .cur_msg_type(cur_msg_type),
    .cur_msg_source(cur_msg_source), .cur_msg_tag(cur_msg_tag),
    .park_timeout(park_timeout), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack(logic f, logic [7:0] t, logic [5:0] s,
                                        logic [25:0] g, logic [63:0] d);
    return {23'd0, f, t, s, g, d};
  endfunction

  task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg1(logic v, logic [7:0] t, logic [5:0] s, logic [25:0] g, logic [63:0] d);
    msg1_valid = v; msg1_type = t; msg1_source = s; msg1_tag = g; msg1_data = d;
  endtask

  task automatic set_msg3(logic v, logic [7:0] t, logic [5:0] s, logic [25:0] g, logic [63:0] d);
    msg3_valid = v; msg3_type = t; msg3_source = s; msg3_tag = g; msg3_data = d;
  endtask

  // Issue monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pipe_valid === 1'b1 && pipe_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        check_eq("issue_payload",
                 pack(pipe_from_msg3, pipe_type, pipe_source, pipe_tag, pipe_data),
                 sb.pop_front());
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_msg1(1'b0, 8'h00, 6'd0, 26'h0, 64'h0);
    set_msg3(1'b1, 8'h00, 6'd0, 26'h0, 64'h0);
    msg2_ready = 1'b1; pipe_ready = 1'b0; pipe_park = 1'b0; pipe_wake = 1'b0;

    // ---- reset state ----
    step(); step();
    check_eq("rst_msg3_ready", 128'(msg3_ready), 128'd0);
    check_eq("rst_msg1_ready", 128'(msg1_ready), 128'd0);
    check_eq("rst_pipe_valid", 128'(pipe_valid), 128'd0);
    check_eq("rst_cur_state", 128'(cur_msg_state), 128'd0);
    check_eq("rst_flags", 128'({park_timeout, proto_err}), 128'd0);
    msg3_valid = 1'b0;
    rst_n = 1'b1;

    // ---- plain msg1 accept ----
    pipe_ready = 1'b1;
    set_msg1(1'b1, 8'h1f, 6'd5, 26'h123, 64'h1111_2222_3333_4444);
    #1;
    check_eq("t1_msg1_ready", 128'(msg1_ready), 128'd1);
    sb.push_back(pack(1'b0, 8'h1f, 6'd5, 26'h123, 64'h1111_2222_3333_4444));
    step();
    msg1_valid = 1'b0;
    #1;
    check_eq("t1_pipe_valid", 128'(pipe_valid), 128'd1);
    step();
    check_eq("t1_idle_pipe_valid", 128'(pipe_valid), 128'd0);
    check_eq("t1_idle_msg1_ready", 128'(msg1_ready), 128'd1);
    check_eq("t1_cur_state", 128'(cur_msg_state), 128'd0);

    // ---- simultaneous arrival ----
    set_msg1(1'b1, 8'h07, 6'd2, 26'h2222, 64'hAAAA);
    set_msg3(1'b1, 8'h33, 6'd4, 26'h3333, 64'hBBBB);
    #1;
    check_eq("t2_msg3_ready", 128'(msg3_ready), 128'd1);
    check_eq("t2_msg1_ready", 128'(msg1_ready), 128'd0);
    sb.push_back(pack(1'b1, 8'h33, 6'd4, 26'h3333, 64'hBBBB));
    step();
    msg3_valid = 1'b0;
    #1;
    check_eq("t2_from_msg3", 128'({pipe_valid, pipe_from_msg3}), 128'd3);
    check_eq("t2_msg1_blocked", 128'(msg1_ready), 128'd0);
    step();
    check_eq("t2_msg1_next_idle", 128'(msg1_ready), 128'd1);
    sb.push_back(pack(1'b0, 8'h07, 6'd2, 26'h2222, 64'hAAAA));
    step();
    msg1_valid = 1'b0;
    #1;
    check_eq("t2_msg1_issue", 128'({pipe_valid, pipe_from_msg3}), 128'd2);
    step();

    // ---- backpressure and payload hold ----
    set_msg1(1'b1, 8'h44, 6'd11, 26'h0DEAD, 64'h0123_4567_89AB_CDEF);
    sb.push_back(pack(1'b0, 8'h44, 6'd11, 26'h0DEAD, 64'h0123_4567_89AB_CDEF));
    step();
    msg1_valid = 1'b0; msg2_ready = 1'b0; pipe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("t3_gated_%0d", i), 128'(pipe_valid), 128'd0);
      step();
    end
    msg2_ready = 1'b1;
    #1;
    check_eq("t3_rise", 128'(pipe_valid), 128'd1);
    check_eq("t3_hold_tag_a", 128'(pipe_tag), 128'h0DEAD);
    step();
    check_eq("t3_hold_tag_b", 128'({pipe_valid, pipe_tag}), 128'({1'b1, 26'h0DEAD}));
    pipe_ready = 1'b1;
    step();
    check_eq("t3_back_idle", 128'(msg1_ready), 128'd1);

    // ---- park, two acks, replay ----
    set_msg1(1'b1, 8'h02, 6'd9, 26'hABC, 64'h5555);
    sb.push_back(pack(1'b0, 8'h02, 6'd9, 26'hABC, 64'h5555));
    step();
    set_msg1(1'b1, 8'h03, 6'd1, 26'h777, 64'h6666);
    pipe_park = 1'b1;
    step();
    pipe_park = 1'b0;
    #1;
    check_eq("t4_parked_state", 128'(cur_msg_state), 128'd1);
    check_eq("t4_parked_fields", 128'({cur_msg_type, cur_msg_source, cur_msg_tag}),
             128'({8'h02, 6'd9, 26'hABC}));
    check_eq("t4_msg1_ready_p1", 128'(msg1_ready), 128'd0);
    set_msg3(1'b1, 8'h40, 6'd3, 26'hABC, 64'h1);
    sb.push_back(pack(1'b1, 8'h40, 6'd3, 26'hABC, 64'h1));
    step();
    msg3_valid = 1'b0;
    #1;
    check_eq("t4_ack1_issue", 128'({pipe_valid, pipe_from_msg3, msg1_ready, msg3_ready}), 128'hC);
    step();
    check_eq("t4_after_ack1", 128'({cur_msg_state, msg1_ready}), 128'd2);
    set_msg3(1'b1, 8'h41, 6'd7, 26'hABC, 64'h2);
    sb.push_back(pack(1'b1, 8'h41, 6'd7, 26'hABC, 64'h2));
    step();
    msg3_valid = 1'b0; pipe_wake = 1'b1;
    step();
    pipe_wake = 1'b0; msg1_valid = 1'b0;
    sb.push_back(pack(1'b0, 8'h02, 6'd9, 26'hABC, 64'h0));
    #1;
    check_eq("t4_replay_state", 128'(cur_msg_state), 128'd2);
    check_eq("t4_replay_src_tag", 128'({pipe_valid, pipe_source, pipe_tag}),
             128'({1'b1, 6'd9, 26'hABC}));
    check_eq("t4_msg1_ready_rp", 128'(msg1_ready), 128'd0);
    step();
    check_eq("t4_done_state", 128'(cur_msg_state), 128'd0);

    // ---- park timeout (PARK_TIMEOUT = 4) ----
    set_msg1(1'b1, 8'h09, 6'd12, 26'h0F0F0, 64'h9999);
    sb.push_back(pack(1'b0, 8'h09, 6'd12, 26'h0F0F0, 64'h9999));
    step();
    msg1_valid = 1'b0; pipe_park = 1'b1;
    step();
    pipe_park = 1'b0; pipe_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check_eq($sformatf("t5_timeout_cyc%0d", c), 128'(park_timeout), (c >= 4) ? 128'd1 : 128'd0);
      if (c < 5) step();
    end
    set_msg3(1'b1, 8'h42, 6'd1, 26'h0F0F0, 64'h3);
    sb.push_back(pack(1'b1, 8'h42, 6'd1, 26'h0F0F0, 64'h3));
    step();
    msg3_valid = 1'b0; pipe_ready = 1'b1; pipe_wake = 1'b1;
    #1;
    check_eq("t5_timeout_ack", 128'(park_timeout), 128'd1);
    step();
    pipe_wake = 1'b0;
    sb.push_back(pack(1'b0, 8'h09, 6'd12, 26'h0F0F0, 64'h0));
    #1;
    check_eq("t5_timeout_replay", 128'({cur_msg_state, park_timeout}), 128'd4);
    step();

    // ---- protocol error, then reset while parked ----
    set_msg3(1'b1, 8'h50, 6'd6, 26'h1234, 64'h7);
    sb.push_back(pack(1'b1, 8'h50, 6'd6, 26'h1234, 64'h7));
    step();
    msg3_valid = 1'b0; pipe_park = 1'b1;
    step();
    pipe_park = 1'b0;
    #1;
    check_eq("t6_proto_err", 128'({proto_err, cur_msg_state}), 128'h4);
    set_msg1(1'b1, 8'h0A, 6'd13, 26'h5678, 64'h8);
    sb.push_back(pack(1'b0, 8'h0A, 6'd13, 26'h5678, 64'h8));
    step();
    msg1_valid = 1'b0; pipe_park = 1'b1;
    step();
    pipe_park = 1'b0; pipe_ready = 1'b0;
    #1;
    check_eq("t6_parked_err", 128'({proto_err, cur_msg_state}), 128'h5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("t6_rst_readies", 128'({msg1_ready, msg3_ready, pipe_valid}), 128'h6);
    check_eq("t6_rst_cur", 128'({cur_msg_state, cur_msg_type, cur_msg_source, cur_msg_tag}), 128'd0);
    check_eq("t6_rst_flags", 128'({proto_err, park_timeout}), 128'd0);
    check_eq("t6_rst_capture", 128'({pipe_type, pipe_source, pipe_tag, pipe_data, pipe_from_msg3}), 128'd0);
    step();

    check_eq("sb_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
